forth_alu_mc: RTL

Parametrised multi-cycle ALU for the Forth stack CPU. It is the successor to the 16-bit single-cycle stack ALU: data width is configurable, it adds start/done sequencing, a shift-add multiplier with double-width products, and an optional restoring divider. It sits between the data-stack top registers (TOS/NOS) and the stack write-back path. The control unit stalls on `o_BUSY`.

---
 rtl/forth_alu_mc_if.sv | 27 ++
 rtl/forth_alu_mc.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/forth_alu_mc_if.sv
// Operand/result bundle between the stack top registers and forth_alu_mc.
// Handshake: i_START is a request sampled only while IDLE (never queued); o_DONE is a one-cycle strobe
// that qualifies o_RESULT/o_RESULT2/o_FAULT, which then hold until the next strobe. There is no backpressure.
interface forth_alu_mc_if #(
  parameter int WIDTH = 16
);
  logic             i_START;
  logic [4:0]       f_aluctrl;
  logic [WIDTH-1:0] i_OP1;
  logic [WIDTH-1:0] i_OP2;
  logic [WIDTH-1:0] o_RESULT;
  logic [WIDTH-1:0] o_RESULT2;
  logic             o_BUSY;
  logic             o_DONE;
  logic             o_FAULT;
  logic [1:0]       dbg_state;

  modport master (
    output i_START, f_aluctrl, i_OP1, i_OP2,
    input  o_RESULT, o_RESULT2, o_BUSY, o_DONE, o_FAULT, dbg_state
  );

  modport slave (
    input  i_START, f_aluctrl, i_OP1, i_OP2,
    output o_RESULT, o_RESULT2, o_BUSY, o_DONE, o_FAULT, dbg_state
  );
endinterface

// File: rtl/forth_alu_mc.sv
// Multi-cycle Forth stack ALU: single-cycle logic/arith ops, shift-add multiplier, optional
// restoring divider built only when FORTH_ALU_MC_DIV_EN is defined.
module forth_alu_mc #(
  parameter int WIDTH = 16,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input logic           c_CLOCK,
  input logic           c_RESET,
  forth_alu_mc_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, FIX = 2'd2} state_t;

  localparam logic [4:0] OP_MUL    = 5'b00110;
  localparam logic [4:0] OP_UMMUL  = 5'b10011;
  localparam logic [4:0] OP_MMUL   = 5'b10100;
  localparam logic [4:0] OP_DIV    = 5'b10000;
  localparam logic [4:0] OP_MOD    = 5'b10001;
  localparam logic [4:0] OP_DIVMOD = 5'b10010;
  localparam logic [WIDTH-1:0] W_LIM  = WIDTH'(WIDTH);
  localparam logic [CNTW-1:0]  W_LAST = CNTW'(WIDTH - 1);

  state_t           state;
  logic [CNTW-1:0]  cnt;
  logic [4:0]       op_q;
  logic [WIDTH-1:0] hi, lo, mcand;
  logic             neg_q;
  logic [WIDTH-1:0] res_q, res2_q;
  logic             done_q, fault_q;

  logic [WIDTH-1:0] abs1, abs2, sc_res;
  logic             sc_fault, is_mul;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [2*WIDTH-1:0] prod, prod_c;
  logic [WIDTH-1:0] fix_res, fix_res2;
  logic             fix_fault;

`ifdef FORTH_ALU_MC_DIV_EN
  logic             rneg_q, dz_q, is_div, iter_div;
  logic [WIDTH:0]   div_sh, div_diff;
  logic [WIDTH-1:0] quo, rem;
`endif

  assign abs1   = bus.i_OP1[WIDTH-1] ? -bus.i_OP1 : bus.i_OP1;
  assign abs2   = bus.i_OP2[WIDTH-1] ? -bus.i_OP2 : bus.i_OP2;
  assign is_mul = (bus.f_aluctrl == OP_MUL) || (bus.f_aluctrl == OP_UMMUL) || (bus.f_aluctrl == OP_MMUL);
`ifdef FORTH_ALU_MC_DIV_EN
  assign is_div   = (bus.f_aluctrl == OP_DIV) || (bus.f_aluctrl == OP_MOD) || (bus.f_aluctrl == OP_DIVMOD);
  assign iter_div = (op_q == OP_DIV) || (op_q == OP_MOD) || (op_q == OP_DIVMOD);
`endif

  // Binary ops take NOS (OP2) as the left operand, Forth-style; unary ops act on TOS (OP1).
  always_comb begin
    sc_res   = '0;
    sc_fault = 1'b0;
    case (bus.f_aluctrl)
      5'd0:  sc_res = (bus.i_OP1 == '0) ? '1 : '0;
      5'd1:  sc_res = abs1;
      5'd2:  sc_res = -bus.i_OP1;
      5'd3:  sc_res = ~bus.i_OP1;
      5'd4:  sc_res = bus.i_OP2 + bus.i_OP1;
      5'd5:  sc_res = bus.i_OP2 - bus.i_OP1;
      5'd7:  sc_res = (abs1 >= W_LIM) ? '0 : (bus.i_OP2 << abs1);
      5'd8:  sc_res = (abs1 >= W_LIM) ? '0 : (bus.i_OP2 >> abs1);
      5'd9:  sc_res = bus.i_OP2 & bus.i_OP1;
      5'd10: sc_res = bus.i_OP2 | bus.i_OP1;
      5'd11: sc_res = bus.i_OP2 ^ bus.i_OP1;
      5'd12: sc_res = ($signed(bus.i_OP2) <  $signed(bus.i_OP1)) ? '1 : '0;
      5'd13: sc_res = ($signed(bus.i_OP2) <= $signed(bus.i_OP1)) ? '1 : '0;
      5'd14: sc_res = (bus.i_OP2 == bus.i_OP1) ? '1 : '0;
      5'd15: sc_res = (bus.i_OP2 != bus.i_OP1) ? '1 : '0;
      default: sc_fault = 1'b1;
    endcase
  end

  // One iteration: multiply shifts {hi,lo} right; divide shifts the dividend out of lo into hi.
  always_comb begin
    mul_sum = {1'b0, hi} + {1'b0, (lo[0] ? mcand : '0)};
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], lo[WIDTH-1:1]};
`ifdef FORTH_ALU_MC_DIV_EN
    div_sh   = {hi, lo[WIDTH-1]};
    div_diff = div_sh - {1'b0, mcand};
    if (iter_div) begin
      step_hi = (div_sh >= {1'b0, mcand}) ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
      step_lo = {lo[WIDTH-2:0], (div_sh >= {1'b0, mcand})};
    end
`endif
  end

  always_comb begin
    prod      = {hi, lo};
    prod_c    = neg_q ? -prod : prod;
    fix_res   = prod_c[WIDTH-1:0];
    fix_res2  = (op_q == OP_MUL) ? '0 : prod_c[2*WIDTH-1:WIDTH];
    fix_fault = 1'b0;
`ifdef FORTH_ALU_MC_DIV_EN
    quo = dz_q ? '1 : (neg_q ? -lo : lo);
    rem = dz_q ? lo : (rneg_q ? -hi : hi);
    if (iter_div) begin
      fix_fault = dz_q;
      fix_res   = (op_q == OP_MOD) ? rem : quo;
      fix_res2  = (op_q == OP_DIVMOD) ? rem : '0;
    end
`endif
  end

  always_ff @(posedge c_CLOCK or posedge c_RESET) begin
    if (c_RESET) begin
      state   <= IDLE;
      cnt     <= '0;
      op_q    <= '0;
      hi      <= '0;
      lo      <= '0;
      mcand   <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
      res2_q  <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
`ifdef FORTH_ALU_MC_DIV_EN
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.i_START) begin
          op_q <= bus.f_aluctrl;
          cnt  <= '0;
          if (is_mul) begin
            hi    <= '0;
            state <= ITER;
            if (bus.f_aluctrl == OP_UMMUL) begin
              lo    <= bus.i_OP2;
              mcand <= bus.i_OP1;
              neg_q <= 1'b0;
            end else begin
              lo    <= abs2;
              mcand <= abs1;
              neg_q <= bus.i_OP1[WIDTH-1] ^ bus.i_OP2[WIDTH-1];
            end
`ifdef FORTH_ALU_MC_DIV_EN
            dz_q <= 1'b0;
          end else if (is_div) begin
            hi     <= '0;
            mcand  <= abs1;
            neg_q  <= bus.i_OP1[WIDTH-1] ^ bus.i_OP2[WIDTH-1];
            rneg_q <= bus.i_OP2[WIDTH-1];
            dz_q   <= (bus.i_OP1 == '0);
            // Divide by zero keeps the raw dividend in lo so FIX can return it as the remainder.
            lo     <= (bus.i_OP1 == '0) ? bus.i_OP2 : abs2;
            state  <= (bus.i_OP1 == '0) ? FIX : ITER;
`endif
          end else begin
            res_q   <= sc_res;
            res2_q  <= '0;
            fault_q <= sc_fault;
            done_q  <= 1'b1;
          end
        end
        ITER: begin
          hi  <= step_hi;
          lo  <= step_lo;
          cnt <= cnt + 1'b1;
          if (cnt == W_LAST) state <= FIX;
        end
        FIX: begin
          res_q   <= fix_res;
          res2_q  <= fix_res2;
          fault_q <= fix_fault;
          done_q  <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_RESULT  = res_q;
  assign bus.o_RESULT2 = res2_q;
  assign bus.o_DONE    = done_q;
  assign bus.o_FAULT   = fault_q;
  assign bus.o_BUSY    = (state != IDLE);
  assign bus.dbg_state = state;
endmodule
